rr_bus_arbiter: RTL

//  Parametrised successor to the encoder+multiplexer bus. Replaces one-hot out-enables with
//  per-source requests. Round-robin arbitration with optional bus lock, registered bus output
//  and valid/ready handshake towards the destination. Sits between the register file
//  (R0-R15, HI, LO, Z_HI, Z_LO, PC, MDR, InPort, C_sign_ext) and all bus consumers.

---
 rtl/bus_defs.sv | 18 +
 rtl/rr_bus_arbiter_if.sv | 32 +++
 rtl/rr_pick.sv | 31 +++
 rtl/rr_bus_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bus_defs.sv
// Shared definitions for the round-robin bus: register-file source indices,
// default data width and the arbiter state encoding.
package bus_defs;

    localparam int DATA_W_DEF = 32;

    localparam int R0  = 0,  R1  = 1,  R2  = 2,  R3  = 3,  R4  = 4,  R5  = 5,  R6  = 6,  R7  = 7;
    localparam int R8  = 8,  R9  = 9,  R10 = 10, R11 = 11, R12 = 12, R13 = 13, R14 = 14, R15 = 15;
    localparam int HI = 16, LO = 17, Z_HI = 18, Z_LO = 19;
    localparam int PC = 20, MDR = 21, INPORT = 22, C_SIGN_EXT = 23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        LOCKED = 2'd2
    } arbState_t;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Bus-side bundle of the arbiter: per-source requests/data/acks and the
// registered valid/ready output towards the consumers.
interface rr_bus_arbiter_if
    import bus_defs::*;
#(
    parameter int N_SRC  = 32,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = $clog2(N_SRC)
);

    logic [N_SRC-1:0]        src_req;
    logic [N_SRC-1:0]        src_lock;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_ack;
    logic                    bus_ready;
    logic [DATA_W-1:0]       bus_out;
    logic                    bus_valid;
    logic [SEL_W-1:0]        bus_sel;
    logic [15:0]             collision_cnt;

    // Master is the source/consumer environment, slave is the arbiter itself.
    modport master (
        output src_req, src_lock, src_data, bus_ready,
        input  src_ack, bus_out, bus_valid, bus_sel, collision_cnt
    );

    modport slave (
        input  src_req, src_lock, src_data, bus_ready,
        output src_ack, bus_out, bus_valid, bus_sel, collision_cnt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr, wrapping
// around, returned both one-hot and as an index.
module rr_pick #(
    parameter int N_SRC = 32,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    int cand;

    // Scan offsets 1..N_SRC so the source at ptr itself has the lowest priority.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = (int'(ptr) + k) % N_SRC;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = SEL_W'(cand);
            end
        end
        grant = any ? (N_SRC'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with optional bounded bus lock, registered output
// and valid/ready handshake towards the destination.
module rr_bus_arbiter
    import bus_defs::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_SRC    = 32,
    parameter int SEL_W    = $clog2(N_SRC),
    parameter int LOCK_MAX = 8
) (
    input logic          clk,
    input logic          clr,
    rr_bus_arbiter_if.slave bus
);

    localparam int LC_W = $clog2(LOCK_MAX + 1);

    arbState_t         state, stateNext;
    logic [SEL_W-1:0]  rrPtr, rrPtrNext, owner, ownerNext;
    logic [SEL_W-1:0]  pickPtr, pickIdx, grantIdx;
    logic [N_SRC-1:0]  pickGrant, ackVec;
    logic [LC_W-1:0]   lockCnt, lockCntNext;
    logic              pickAny, accept, ownerHolds, grantValid, reqMulti;
    logic [DATA_W-1:0] busOut;
    logic [SEL_W-1:0]  busSel;
    logic              busValid;
    logic [15:0]       collisionCnt;

    assign accept     = !busValid || bus.bus_ready;
    assign reqMulti   = |(bus.src_req & (bus.src_req - N_SRC'(1)));
    assign ownerHolds = (state == LOCKED) && bus.src_req[owner] && bus.src_lock[owner]
                        && (lockCnt < LC_W'(LOCK_MAX));
    // On a lock release the search restarts just after the old owner.
    assign pickPtr    = (state == LOCKED) ? owner : rrPtr;

    rr_pick #(.N_SRC(N_SRC), .SEL_W(SEL_W)) picker (
        .req   (bus.src_req),
        .ptr   (pickPtr),
        .grant (pickGrant),
        .idx   (pickIdx),
        .any   (pickAny)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            rrPtr   <= SEL_W'(N_SRC - 1);
            owner   <= '0;
            lockCnt <= '0;
        end else begin
            state   <= stateNext;
            rrPtr   <= rrPtrNext;
            owner   <= ownerNext;
            lockCnt <= lockCntNext;
        end
    end

    // Arbitration only happens on accept cycles; a stall freezes everything.
    always_comb begin
        stateNext   = state;
        rrPtrNext   = rrPtr;
        ownerNext   = owner;
        lockCntNext = lockCnt;
        grantValid  = 1'b0;
        grantIdx    = pickIdx;
        ackVec      = '0;
        if (accept) begin
            if (ownerHolds) begin
                grantValid  = 1'b1;
                grantIdx    = owner;
                lockCntNext = lockCnt + LC_W'(1);
                ackVec      = N_SRC'(1) << owner;
            end else begin
                if (state == LOCKED) begin
                    rrPtrNext   = owner;
                    lockCntNext = '0;
                end
                grantValid = pickAny;
                ackVec     = pickGrant;
                if (!pickAny) begin
                    stateNext = IDLE;
                end else if (bus.src_lock[pickIdx]) begin
                    stateNext   = LOCKED;
                    ownerNext   = pickIdx;
                    lockCntNext = LC_W'(1);
                end else begin
                    stateNext = XFER;
                    rrPtrNext = pickIdx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busOut   <= '0;
            busSel   <= '0;
            busValid <= 1'b0;
        end else if (accept) begin
            if (grantValid) begin
                busOut   <= bus.src_data[grantIdx*DATA_W +: DATA_W];
                busSel   <= grantIdx;
                busValid <= 1'b1;
            end else begin
                busValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            collisionCnt <= '0;
        end else if (accept && reqMulti && (collisionCnt != 16'hFFFF)) begin
            collisionCnt <= collisionCnt + 16'd1;
        end
    end

    assign bus.src_ack       = ackVec;
    assign bus.bus_out       = busOut;
    assign bus.bus_sel       = busSel;
    assign bus.bus_valid     = busValid;
    assign bus.collision_cnt = collisionCnt;

endmodule
